// File: rtl/pixel_writer.sv
// Rasterizer pixel sink: drops off-screen and repeated pixels, buffers them in a
// small FIFO and writes each to framebuffer memory over a req/ack handshake.
module pixel_writer #(
   parameter int unsigned WIDTH        = 640,
   parameter int unsigned HEIGHT       = 480,
   parameter int unsigned WIDTH_BITS   = 10,
   parameter int unsigned HEIGHT_BITS  = 9,
   parameter int unsigned CHANNEL_BITS = 8,
   parameter int unsigned ADDR_BITS    = 19,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pix_valid,
   input  logic [WIDTH_BITS-1:0]     pix_x,
   input  logic [HEIGHT_BITS-1:0]    pix_y,
   input  logic [CHANNEL_BITS-1:0]   pix_r,
   input  logic [CHANNEL_BITS-1:0]   pix_g,
   input  logic [CHANNEL_BITS-1:0]   pix_b,
   input  logic                      draw_done,
   output logic                      in_ready,
   output logic                      mem_req,
   output logic [ADDR_BITS-1:0]      mem_addr,
   output logic [3*CHANNEL_BITS-1:0] mem_wdata,
   input  logic                      mem_ack,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      overflow
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned DATA_W = 3 * CHANNEL_BITS;
   localparam int unsigned PIX_W  = WIDTH_BITS + HEIGHT_BITS + DATA_W;
   localparam logic [PTR_W:0] PTR_ONE = 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   logic [ADDR_BITS-1:0] addr_mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]    data_mem_q [FIFO_DEPTH];
   logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PIX_W-1:0]     last_q;
   logic                 last_vld_q;
   state_t               state_q, state_d;
   logic                 done_pend_q, done_pend_d;
   logic                 mem_req_q, busy_q, frame_done_q, overflow_q;
   logic [ADDR_BITS-1:0] mem_addr_q, head_addr;
   logic [DATA_W-1:0]    mem_wdata_q, head_data;

   logic [PIX_W-1:0]     pix_cur;
   logic [DATA_W-1:0]    pix_data;
   logic [ADDR_BITS-1:0] pix_addr;
   logic                 in_range, dup, accept, full, push, pop, empty_d;

   assign pix_data = {pix_r, pix_g, pix_b};
   assign pix_cur  = {pix_x, pix_y, pix_data};
   assign pix_addr = ADDR_BITS'(pix_y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(pix_x);
   assign in_range = pix_valid && (32'(pix_x) < WIDTH) && (32'(pix_y) < HEIGHT);
   assign dup      = last_vld_q && (pix_cur == last_q);
   assign accept   = in_range && !dup;
   assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign push     = accept && !full;
   assign pop      = mem_req_q && mem_ack;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      empty_d = (wr_ptr_d == rd_ptr_d);
      // Next head is the incoming pixel when it lands in the slot about to be presented
      if (push && (wr_ptr_q == rd_ptr_d)) begin
         head_addr = pix_addr;
         head_data = pix_data;
      end else begin
         head_addr = addr_mem_q[rd_ptr_d[PTR_W-1:0]];
         head_data = data_mem_q[rd_ptr_d[PTR_W-1:0]];
      end
   end

   always_comb begin
      state_d     = state_q;
      done_pend_d = done_pend_q;
      case (state_q)
         IDLE: if (accept || draw_done) begin
            state_d     = RUN;
            done_pend_d = draw_done;
         end
         RUN: if (draw_done || done_pend_q) begin
            state_d     = DRAIN;
            done_pend_d = 1'b0;
         end
         DRAIN: if (!mem_req_q && !accept) state_d = DONE;
         DONE: state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q[PTR_W-1:0]] <= pix_addr;
         data_mem_q[wr_ptr_q[PTR_W-1:0]] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         done_pend_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         last_q       <= '0;
         last_vld_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         done_pend_q  <= done_pend_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_req_q    <= !empty_d;
         if (!empty_d) begin
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_data;
         end
         busy_q       <= (state_d != IDLE);
         frame_done_q <= (state_d == DONE);
         if (accept && full) overflow_q <= 1'b1;
         if (push) begin
            last_q     <= pix_cur;
            last_vld_q <= 1'b1;
         end else if (state_d == DONE) begin
            last_vld_q <= 1'b0;
         end
      end
   end

   assign in_ready   = !full;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: expected writes are queued as pixels are
// driven and compared against every mem_req/mem_ack handshake.
module tb_pixel_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        draw_done;
   logic        in_ready;
   logic        mem_req;
   logic [18:0] mem_addr;
   logic [23:0] mem_wdata;
   logic        mem_ack;
   logic        busy;
   logic        frame_done;
   logic        overflow;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   logic [42:0] exp_q[$];

   always #5 clk = ~clk;

   pixel_writer #(
      .WIDTH(640), .HEIGHT(480), .WIDTH_BITS(10), .HEIGHT_BITS(9),
      .CHANNEL_BITS(8), .ADDR_BITS(19), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .draw_done(draw_done),
      .in_ready(in_ready), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy),
      .frame_done(frame_done), .overflow(overflow)
   );

   // A handshake seen at the negedge completes on the following posedge.
   always @(negedge clk) begin
      logic [42:0] e;
      if (!rst && mem_req && mem_ack) begin
         total++;
         wr_cnt++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write_unexpected got addr=%0d data=%h required none", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               bad++;
               $display("FAIL write_data got addr=%0d data=%h required addr=%0d data=%h",
                        mem_addr, mem_wdata, e[42:24], e[23:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input bit v, input int x, input int y, input logic [23:0] rgb);
      pix_valid = v;
      pix_x = 10'(x);
      pix_y = 9'(y);
      {pix_r, pix_g, pix_b} = rgb;
   endtask

   task automatic expect_wr(input int x, input int y, input logic [23:0] rgb);
      exp_q.push_back({19'(y * 640 + x), rgb});
   endtask

   task automatic wait_frame(input int max_cyc, input bit rand_ack, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         if (frame_done) seen = 1'b1;
         else begin
            if (rand_ack) mem_ack = 1'($urandom_range(0, 1));
            tick();
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; pix_valid = 1'b0; draw_done = 1'b0; mem_ack = 1'b0;
      set_pix(0, 0, 0, 24'h0);
      repeat (3) tick();
      total++;
      if ({mem_req, mem_addr, mem_wdata} !== 44'h0) begin
         bad++; $display("FAIL reset_mem got req=%b addr=%0d data=%h required 0", mem_req, mem_addr, mem_wdata);
      end
      total++;
      if ({busy, frame_done, overflow} !== 3'b000) begin
         bad++; $display("FAIL reset_status got busy/done/ovf=%b required 000", {busy, frame_done, overflow});
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready got %b required 1", in_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bit seen;
      int w0 = wr_cnt;
      mem_ack = 1'b1;
      expect_wr(10, 5, 24'hFF0000);
      expect_wr(11, 5, 24'hFF0000);
      set_pix(1, 10, 5, 24'hFF0000);
      tick();
      total++;
      if ({mem_req, mem_addr} !== {1'b1, 19'd3210}) begin
         bad++; $display("FAIL basic_latency got req=%b addr=%0d required req=1 addr=3210", mem_req, mem_addr);
      end
      set_pix(1, 11, 5, 24'hFF0000);
      tick();
      set_pix(0, 0, 0, 24'h0);
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      wait_frame(20, 0, seen);
      total++;
      if (!seen || exp_q.size() != 0 || wr_cnt - w0 != 2) begin
         bad++; $display("FAIL basic_frame got seen=%b pending=%0d writes=%0d required 1/0/2", seen, exp_q.size(), wr_cnt - w0);
      end
      tick();
      total++;
      if ({frame_done, busy} !== 2'b00) begin
         bad++; $display("FAIL basic_after got done/busy=%b required 00", {frame_done, busy});
      end
   endtask

   task automatic test_empty_frame();
      int w0 = wr_cnt;
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      tick();
      total++;
      if (frame_done !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL empty_early got done=%b busy=%b required 0/1", frame_done, busy);
      end
      tick();
      total++;
      if (frame_done !== 1'b1 || wr_cnt != w0) begin
         bad++; $display("FAIL empty_done got done=%b writes=%0d required 1/0", frame_done, wr_cnt - w0);
      end
      repeat (2) tick();
   endtask

   task automatic test_filter();
      bit seen;
      int w0 = wr_cnt;
      mem_ack = 1'b1;
      expect_wr(0, 0, 24'h010203);
      set_pix(1, 640, 480, 24'h111111); tick();
      set_pix(1, 0, 0, 24'h010203);     tick();
      set_pix(1, 700, 5, 24'h222222);   tick();
      set_pix(1, 5, 480, 24'h333333);   tick();
      set_pix(1, 0, 0, 24'h010203);     tick();
      set_pix(1, 640, 0, 24'h444444);   tick();
      set_pix(0, 1, 1, 24'h555555);     tick();
      set_pix(0, 0, 0, 24'h0);
      draw_done = 1'b1; tick(); draw_done = 1'b0;
      wait_frame(20, 0, seen);
      total++;
      if (!seen || exp_q.size() != 0 || wr_cnt - w0 != 1) begin
         bad++; $display("FAIL filter_count got seen=%b pending=%0d writes=%0d required 1/0/1", seen, exp_q.size(), wr_cnt - w0);
      end
      repeat (2) tick();
   endtask

   task automatic test_dup();
      bit seen;
      int w0 = wr_cnt;
      mem_ack = 1'b1;
      expect_wr(20, 20, 24'h123456);
      expect_wr(639, 479, 24'hABCDEF);
      set_pix(1, 20, 20, 24'h123456);
      repeat (5) tick();
      set_pix(1, 639, 479, 24'hABCDEF);
      tick();
      set_pix(0, 0, 0, 24'h0);
      draw_done = 1'b1; tick(); draw_done = 1'b0;
      wait_frame(20, 0, seen);
      total++;
      if (!seen || exp_q.size() != 0 || wr_cnt - w0 != 2) begin
         bad++; $display("FAIL dup_count got seen=%b pending=%0d writes=%0d required 1/0/2", seen, exp_q.size(), wr_cnt - w0);
      end
      repeat (2) tick();
      // Same pixel in a new frame is no longer a duplicate.
      w0 = wr_cnt;
      expect_wr(639, 479, 24'hABCDEF);
      set_pix(1, 639, 479, 24'hABCDEF);
      tick();
      set_pix(0, 0, 0, 24'h0);
      draw_done = 1'b1; tick(); draw_done = 1'b0;
      wait_frame(20, 0, seen);
      total++;
      if (!seen || wr_cnt - w0 != 1) begin
         bad++; $display("FAIL dup_new_frame got seen=%b writes=%0d required 1/1", seen, wr_cnt - w0);
      end
      repeat (2) tick();
   endtask

   task automatic test_overflow();
      bit seen;
      int w0 = wr_cnt;
      mem_ack = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_pix(1, 100 + i, 7, {8'(i), 8'h55, 8'hAA});
         if (i < 8) expect_wr(100 + i, 7, {8'(i), 8'h55, 8'hAA});
         tick();
         if (i == 7) begin
            total++;
            if (in_ready !== 1'b0) begin
               bad++; $display("FAIL ovf_in_ready got %b required 0", in_ready);
            end
         end
      end
      set_pix(0, 0, 0, 24'h0);
      total++;
      if (overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_flag got %b required 1", overflow);
      end
      repeat (3) tick();
      total++;
      if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 19'd4580, 24'h0055AA}) begin
         bad++; $display("FAIL ovf_stall got req=%b addr=%0d data=%h required 1/4580/0055aa", mem_req, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      draw_done = 1'b1; tick(); draw_done = 1'b0;
      wait_frame(40, 0, seen);
      total++;
      if (!seen || exp_q.size() != 0 || wr_cnt - w0 != 8 || overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_drain got seen=%b pending=%0d writes=%0d ovf=%b required 1/0/8/1",
                         seen, exp_q.size(), wr_cnt - w0, overflow);
      end
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      int w0 = wr_cnt;
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_pix(1, 300 + i, 9, 24'h777700 + 24'(i));
         tick();
      end
      set_pix(0, 0, 0, 24'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({mem_req, overflow, busy, in_ready} !== 4'b0001) begin
         bad++; $display("FAIL rstmid_state got req/ovf/busy/rdy=%b required 0001", {mem_req, overflow, busy, in_ready});
      end
      mem_ack = 1'b1;
      repeat (10) tick();
      total++;
      if (wr_cnt != w0) begin
         bad++; $display("FAIL rstmid_writes got %0d required 0", wr_cnt - w0);
      end
   endtask

   task automatic test_raster();
      bit seen;
      int idx = 0;
      int guard = 0;
      int w0 = wr_cnt;
      logic [23:0] rgb;
      while (idx < 100 && guard < 3000) begin
         mem_ack = 1'($urandom_range(0, 1));
         if (in_ready) begin
            rgb = {8'(idx), 8'($urandom), 8'(idx) ^ 8'h3C};
            set_pix(1, idx, 200, rgb);
            expect_wr(idx, 200, rgb);
            if (idx == 99) draw_done = 1'b1;
            idx++;
         end else begin
            set_pix(0, 0, 0, 24'h0);
         end
         tick();
         draw_done = 1'b0;
         guard++;
      end
      set_pix(0, 0, 0, 24'h0);
      total++;
      if (idx != 100) begin
         bad++; $display("FAIL raster_feed got %0d pixels required 100", idx);
      end
      wait_frame(2000, 1, seen);
      total++;
      if (!seen || exp_q.size() != 0) begin
         bad++; $display("FAIL raster_done got seen=%b pending=%0d required 1/0", seen, exp_q.size());
      end
      mem_ack = 1'b1;
      repeat (4) tick();
      total++;
      if (wr_cnt - w0 != 100) begin
         bad++; $display("FAIL raster_writes got %0d required 100", wr_cnt - w0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty_frame();
      test_filter();
      test_dup();
      test_overflow();
      test_reset_mid();
      test_raster();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1);
   end

endmodule
